lsu_align_split: RTL and testbench

- Load/store alignment unit between the core's memory-access stage and `datamem`.
- Aligned loads and stores pass straight through to `datamem` in one cycle.
- Misaligned word/half accesses are split into sequential byte accesses, one per cycle, with a stall to the core. Split-load bytes are reassembled little-endian and sign/zero extended.
- Keeps a saturating count of split accesses for performance monitoring.

---
 rtl/lsu_align_split_if.sv | 53 +++++
 rtl/lsu_align_split.sv | 235 +++++++++++++++++++++++
 tb/tb_lsu_align_split.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_align_split_if.sv
// lsu_align_split_if
//   Bundle of every signal between the core's memory-access stage, the
//   load/store alignment unit and the data memory.
//
//   Core -> unit : req_read, req_write, req_size, req_unsigned, req_addr,
//                  req_wdata
//   Unit -> core : stall, load_data, load_valid, fault, split_count
//   Unit -> mem  : mem_WriteEn, mem_address, mem_datain, mem_datasize,
//                  mem_datatype
//   Mem  -> unit : mem_dataout (combinational read of mem_address)
//
//   slave  modport : the alignment unit itself
//   master modport : the environment (core plus memory) around it
interface lsu_align_split_if #(
    parameter int CNT_W = 16
);
    // Core request side
    logic             req_read;
    logic             req_write;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;

    // Core response side
    logic             stall;
    logic [31:0]      load_data;
    logic             load_valid;
    logic             fault;
    logic [CNT_W-1:0] split_count;

    // Data memory side
    logic             mem_WriteEn;
    logic [31:0]      mem_address;
    logic [31:0]      mem_datain;
    logic [1:0]       mem_datasize;
    logic             mem_datatype;
    logic [31:0]      mem_dataout;

    modport slave (
        input  req_read, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_dataout,
        output stall, load_data, load_valid, fault, split_count,
        output mem_WriteEn, mem_address, mem_datain, mem_datasize, mem_datatype
    );

    modport master (
        output req_read, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_dataout,
        input  stall, load_data, load_valid, fault, split_count,
        input  mem_WriteEn, mem_address, mem_datain, mem_datasize, mem_datatype
    );
endinterface

// File: rtl/lsu_align_split.sv
// lsu_align_split
//   Load/store alignment unit sitting between the core's memory-access
//   stage and the data memory.
//
//   * Aligned accesses, and every byte access, are forwarded to memory
//     combinationally (zero latency, no stall).
//   * A misaligned word (addr[1:0] != 0) or half (addr[0] = 1) is broken
//     into N byte accesses (N = 4 / 2) on consecutive cycles. stall is held
//     high for the first N-1 cycles; load bytes are gathered little-endian
//     and the final byte is merged combinationally in the last cycle.
//   * With ALLOW_MISALIGNED = 0 such an access is refused instead: fault
//     pulses for the cycle and memory is left untouched.
//   * split_count counts completed split accesses and saturates.
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high; forces every output to 0 while high
//     bus    lsu_align_split_if.slave (core request/response + memory bus)
//
//   Parameters:
//     ALLOW_MISALIGNED  1 = split misaligned accesses, 0 = fault them
//     CNT_W             width of split_count (must match the interface)
module lsu_align_split #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic               clk,
    input  logic               reset,
    lsu_align_split_if.slave   bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SPLIT = 1'b1
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Control state
    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Request captured at the start of a split; only meaningful in S_SPLIT
    logic             lat_wr_q;
    logic             lat_half_q;
    logic             lat_uns_q;
    logic [31:0]      lat_addr_q;
    logic [31:0]      lat_wdata_q;
    logic             latch_en;

    logic             req_any;
    logic             misaligned;
    logic [1:0]       last_idx;
    logic             last_byte;
    logic [7:0]       wr_byte;
    logic [31:0]      split_raw;

    // Sign/zero extension of a reassembled split load. A half result sits
    // in raw[15:0]; a word result needs no extension.
    function automatic logic [31:0] extend_load(input logic        half,
                                                input logic        uns,
                                                input logic [31:0] raw);
        logic [31:0] res;
        if (half) begin
            res = {(uns ? 16'h0000 : {16{raw[15]}}), raw[15:0]};
        end else begin
            res = raw;
        end
        return res;
    endfunction

    assign req_any    = bus.req_read | bus.req_write;
    assign misaligned = ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00)) ||
                        ((bus.req_size == SZ_HALF) && bus.req_addr[0]);

    assign last_idx  = lat_half_q ? 2'd1 : 2'd3;
    assign last_byte = (idx_q == last_idx);

    // Store byte selected by the current split index
    always_comb begin
        wr_byte = lat_wdata_q[7:0];
        case (idx_q)
            2'd1:    wr_byte = lat_wdata_q[15:8];
            2'd2:    wr_byte = lat_wdata_q[23:16];
            2'd3:    wr_byte = lat_wdata_q[31:24];
            default: wr_byte = lat_wdata_q[7:0];
        endcase
    end

    // Final byte comes straight from memory; earlier ones from the buffer
    assign split_raw = lat_half_q ? {16'h0000, bus.mem_dataout[7:0], buf_q[7:0]}
                                  : {bus.mem_dataout[7:0], buf_q};

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            buf_q   <= 24'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched request fields carry data only, so they need no reset
    always_ff @(posedge clk) begin
        if (latch_en) begin
            lat_wr_q    <= bus.req_write;
            lat_half_q  <= (bus.req_size == SZ_HALF);
            lat_uns_q   <= bus.req_unsigned;
            lat_addr_q  <= bus.req_addr;
            lat_wdata_q <= bus.req_wdata;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Byte 0 is issued in this very cycle, so its data is
                // captured now and the split resumes at index 1.
                if (ALLOW_MISALIGNED && req_any && misaligned) begin
                    latch_en    = 1'b1;
                    state_d     = S_SPLIT;
                    idx_d       = 2'd1;
                    buf_d[7:0]  = bus.mem_dataout[7:0];
                end
            end

            S_SPLIT: begin
                if (last_byte) begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                    // Only bytes 1 and 2 are ever buffered here; byte 3 is
                    // always the final one and is merged combinationally.
                    case (idx_q)
                        2'd1:    buf_d[15:8]  = bus.mem_dataout[7:0];
                        2'd2:    buf_d[23:16] = bus.mem_dataout[7:0];
                        default: ;
                    endcase
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        bus.stall        = 1'b0;
        bus.load_data    = 32'h0;
        bus.load_valid   = 1'b0;
        bus.fault        = 1'b0;
        bus.mem_WriteEn  = 1'b0;
        bus.mem_address  = 32'h0;
        bus.mem_datain   = 32'h0;
        bus.mem_datasize = SZ_WORD;
        bus.mem_datatype = 1'b0;

        // Reset blanks every output, even the combinational pass-through,
        // so nothing can reach memory while reset is asserted.
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        if (!misaligned) begin
                            bus.mem_address  = bus.req_addr;
                            bus.mem_datasize = bus.req_size;
                            bus.mem_datatype = bus.req_unsigned;
                            bus.mem_datain   = bus.req_wdata;
                            bus.mem_WriteEn  = bus.req_write;
                            // A write wins when both request lines are high
                            bus.load_valid   = bus.req_read & ~bus.req_write;
                            if (bus.req_read && !bus.req_write) begin
                                bus.load_data = bus.mem_dataout;
                            end
                        end else if (ALLOW_MISALIGNED) begin
                            bus.mem_address  = bus.req_addr;
                            bus.mem_datasize = SZ_BYTE;
                            bus.mem_datatype = 1'b1;
                            bus.mem_datain   = {24'h0, bus.req_wdata[7:0]};
                            bus.mem_WriteEn  = bus.req_write;
                            bus.stall        = 1'b1;
                        end else begin
                            bus.fault = 1'b1;
                        end
                    end
                end

                S_SPLIT: begin
                    bus.mem_address  = lat_addr_q + {30'h0, idx_q};
                    bus.mem_datasize = SZ_BYTE;
                    bus.mem_datatype = 1'b1;
                    bus.mem_datain   = {24'h0, wr_byte};
                    bus.mem_WriteEn  = lat_wr_q;
                    bus.stall        = ~last_byte;
                    if (last_byte && !lat_wr_q) begin
                        bus.load_valid = 1'b1;
                        bus.load_data  = extend_load(lat_half_q, lat_uns_q, split_raw);
                    end
                end

                default: ;
            endcase
        end
    end

    assign bus.split_count = cnt_q;

endmodule

// File: tb/tb_lsu_align_split.sv
module tb_lsu_align_split;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Main DUT (splits), a refusing DUT and a narrow-counter DUT that both
    // shadow the main request stream.
    lsu_align_split_if #(.CNT_W(16)) bus   ();
    lsu_align_split_if #(.CNT_W(16)) bus_n ();
    lsu_align_split_if #(.CNT_W(2))  bus_s ();

    lsu_align_split #(.ALLOW_MISALIGNED(1'b1), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    lsu_align_split #(.ALLOW_MISALIGNED(1'b0), .CNT_W(16)) u_nomis (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n.slave)
    );

    lsu_align_split #(.ALLOW_MISALIGNED(1'b1), .CNT_W(2)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    assign bus_n.req_read     = bus.req_read;
    assign bus_n.req_write    = bus.req_write;
    assign bus_n.req_size     = bus.req_size;
    assign bus_n.req_unsigned = bus.req_unsigned;
    assign bus_n.req_addr     = bus.req_addr;
    assign bus_n.req_wdata    = bus.req_wdata;
    assign bus_n.mem_dataout  = bus.mem_dataout;

    assign bus_s.req_read     = bus.req_read;
    assign bus_s.req_write    = bus.req_write;
    assign bus_s.req_size     = bus.req_size;
    assign bus_s.req_unsigned = bus.req_unsigned;
    assign bus_s.req_addr     = bus.req_addr;
    assign bus_s.req_wdata    = bus.req_wdata;
    assign bus_s.mem_dataout  = bus.mem_dataout;

    // Data memory seen by the main DUT (256-byte window, address wraps)
    logic [7:0] env_mem [256] = '{default: 8'h00};
    logic [7:0] env_a;
    assign env_a = bus.mem_address[7:0];

    always_comb begin
        bus.mem_dataout = 32'h0;
        case (bus.mem_datasize)
            2'b00: bus.mem_dataout = {env_mem[env_a + 8'd3], env_mem[env_a + 8'd2],
                                      env_mem[env_a + 8'd1], env_mem[env_a]};
            2'b01: bus.mem_dataout = {(bus.mem_datatype ? 16'h0000 : {16{env_mem[env_a + 8'd1][7]}}),
                                      env_mem[env_a + 8'd1], env_mem[env_a]};
            default: bus.mem_dataout = {(bus.mem_datatype ? 24'h0 : {24{env_mem[env_a][7]}}),
                                        env_mem[env_a]};
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_WriteEn) begin
            env_mem[env_a] <= bus.mem_datain[7:0];
            if (bus.mem_datasize == 2'b00 || bus.mem_datasize == 2'b01)
                env_mem[env_a + 8'd1] <= bus.mem_datain[15:8];
            if (bus.mem_datasize == 2'b00) begin
                env_mem[env_a + 8'd2] <= bus.mem_datain[23:16];
                env_mem[env_a + 8'd3] <= bus.mem_datain[31:24];
            end
        end
    end

    // Reference model state: memory contents at access granularity and the
    // number of split accesses completed since the last reset.
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    int         exp_splits = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat_cnt(input int n, input int max);
        return 32'((n > max) ? max : n);
    endfunction

    task automatic drop_req();
        bus.req_read     = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_stall",  32'(bus.stall),       32'd0);
        chk("idle_we",     32'(bus.mem_WriteEn), 32'd0);
        chk("idle_lvalid", 32'(bus.load_valid),  32'd0);
        chk("idle_ldata",  bus.load_data,        32'd0);
        chk("idle_fault",  32'(bus_n.fault),     32'd0);
        @(posedge clk); #1;
    endtask

    // One core access, checked cycle by cycle against the spec's rules.
    task automatic access(input bit wr, input bit rd_also, input logic [1:0] size,
                          input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int          cyc;
        bit          mis;
        bit          is_ld;
        logic [63:0] acc;
        logic [31:0] exp_ld;

        n     = size[1] ? 1 : (size[0] ? 2 : 4);
        mis   = (size == 2'b00 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]);
        cyc   = mis ? n : 1;
        is_ld = !wr;

        acc = 64'h0;
        for (int i = 0; i < n; i++)
            acc = acc | (64'(ref_mem[8'(addr + 32'(i))]) << (8 * i));
        if (!uns && acc[8 * n - 1])
            acc = acc | (~64'h0 << (8 * n));
        exp_ld = acc[31:0];

        bus.req_write    = wr;
        bus.req_read     = is_ld | rd_also;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;

        for (int c = 0; c < cyc; c++) begin
            bit fin;
            fin = (c == cyc - 1);
            @(negedge clk);
            chk("stall",  32'(bus.stall),        32'(!fin));
            chk("maddr",  bus.mem_address,       mis ? addr + 32'(c) : addr);
            chk("we",     32'(bus.mem_WriteEn),  32'(wr));
            chk("dsize",  32'(bus.mem_datasize), mis ? 32'd2 : 32'(size));
            chk("dtype",  32'(bus.mem_datatype), mis ? 32'd1 : 32'(uns));
            if (wr)
                chk("wdata", bus.mem_datain, mis ? {24'h0, wdata[8 * c +: 8]} : wdata);
            chk("lvalid", 32'(bus.load_valid),   32'(is_ld && fin));
            chk("ldata",  bus.load_data,         (is_ld && fin) ? exp_ld : 32'h0);
            if (c == 0) begin
                chk("nm_fault",  32'(bus_n.fault),       32'(mis));
                chk("nm_we",     32'(bus_n.mem_WriteEn), 32'(wr && !mis));
                chk("nm_stall",  32'(bus_n.stall),       32'd0);
                chk("nm_lvalid", 32'(bus_n.load_valid),  32'(is_ld && !mis));
            end
            @(posedge clk); #1;
        end
        drop_req();

        if (wr)
            for (int i = 0; i < n; i++)
                ref_mem[8'(addr + 32'(i))] = wdata[8 * i +: 8];
        if (mis) exp_splits++;

        chk("split_count", 32'(bus.split_count),   sat_cnt(exp_splits, 65535));
        chk("sat_count",   32'(bus_s.split_count), sat_cnt(exp_splits, 3));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drop_req();
        bus.req_read = 1'b1;
        bus.req_addr = 32'h4;
        repeat (2) @(posedge clk);
        #1;
        // Outputs are forced to zero while reset is high, even with a request
        chk("rst_stall",  32'(bus.stall),       32'd0);
        chk("rst_lvalid", 32'(bus.load_valid),  32'd0);
        chk("rst_ldata",  bus.load_data,        32'd0);
        chk("rst_maddr",  bus.mem_address,      32'd0);
        chk("rst_count",  32'(bus.split_count), 32'd0);
        drop_req();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        idle_check();

        // Aligned pass-through, then splits of word / half loads
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h04, 32'h12345678);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h04, 32'h0);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h08, 32'h9ABCDEF0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h06, 32'h0);
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h07, 32'h0);
        access(1'b0, 1'b0, 2'b01, 1'b1, 32'h07, 32'h0);

        // Split store, read back through aligned words
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0D, 32'hAABBCCDD);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h0C, 32'h0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);

        // Byte accesses, including size 11, and read+write treated as store
        access(1'b0, 1'b0, 2'b11, 1'b0, 32'h0F, 32'h0);
        access(1'b0, 1'b0, 2'b10, 1'b1, 32'h0F, 32'h0);
        access(1'b1, 1'b1, 2'b01, 1'b0, 32'h31, 32'h0000BEEF);
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'h31, 32'h0);

        // Reset in the middle of a split store: two bytes land, no rollback
        bus.req_write = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h21;
        bus.req_wdata = 32'h11223344;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ab_stall", 32'(bus.stall), 32'd1);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("ab_stall_rst", 32'(bus.stall),       32'd0);
        chk("ab_we_rst",    32'(bus.mem_WriteEn), 32'd0);
        chk("ab_count_rst", 32'(bus.split_count), 32'd0);
        drop_req();
        ref_mem[8'h21] = 8'h44;
        ref_mem[8'h22] = 8'h33;
        exp_splits = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h24, 32'h0);

        // Misaligned load seen by the refusing instance, then fault clears
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'h02, 32'h0);
        idle_check();

        // Randomised traffic; also drives the 2-bit counter into saturation
        for (int k = 0; k < 80; k++) begin
            bit          wr;
            logic [1:0]  sz;
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            access(wr, wr && ($urandom_range(0, 3) == 0), sz, 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 250)), $urandom);
            if ($urandom_range(0, 4) == 0) idle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
